// File: rtl/chromatic_matrix_apply.sv
// rtl/chromatic_matrix_apply.sv - 3x3 Q16.16 colour matrix on an RGB stream, frame-synchronous matrix commit
module chromatic_matrix_apply #(
    parameter int PIX_W     = 8,
    parameter int FRAC_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [287:0]       comp_matrix,
    input  logic               matrix_valid,
    input  logic [3*PIX_W-1:0] in_rgb,
    input  logic               in_sof,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [3*PIX_W-1:0] out_rgb,
    output logic               out_sof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               matrix_pending
);
    localparam int COEF_W = 32;
    localparam int PROD_W = COEF_W + PIX_W + 1;
    localparam int SUM_W  = PROD_W + 2;

    localparam logic signed [COEF_W-1:0] ONE  = COEF_W'(1) <<< FRAC_BITS;
    localparam logic signed [SUM_W-1:0]  HALF = SUM_W'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [SUM_W-1:0]  MAXV = SUM_W'((1 << PIX_W) - 1);

    logic signed [COEF_W-1:0] active_q [9];
    logic signed [COEF_W-1:0] shadow_q [9];
    logic signed [COEF_W-1:0] sel_m    [9];
    logic                     pending_q;

    logic en;
    logic accept;
    logic use_shadow;
    logic commit;

    logic signed [PROD_W-1:0] p1_q [9];
    logic                     v1_q, sof1_q;
    logic signed [SUM_W-1:0]  s2_q [3];
    logic                     v2_q, sof2_q;
    logic signed [SUM_W-1:0]  rnd  [3];
    logic [3*PIX_W-1:0]       res_rgb;
    logic [3*PIX_W-1:0]       rgb3_q;
    logic                     v3_q, sof3_q;

    assign en             = ~v3_q | out_ready;
    assign in_ready       = en;
    assign accept         = in_valid & en;
    assign use_shadow     = in_sof & pending_q;
    assign commit         = accept & use_shadow;
    assign matrix_pending = pending_q;
    assign out_rgb        = rgb3_q;
    assign out_sof        = sof3_q;
    assign out_valid      = v3_q;

    // An SOF pixel that commits already uses the shadow, so the matrix travels with it
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            sel_m[k] = use_shadow ? shadow_q[k] : active_q[k];
        end
    end

    // Shadow load on strobe, commit to active on an accepted SOF; a same-cycle strobe re-arms pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                active_q[k] <= (k % 4 == 0) ? ONE : '0;
                shadow_q[k] <= (k % 4 == 0) ? ONE : '0;
            end
            pending_q <= 1'b0;
        end else begin
            if (commit) begin
                active_q <= shadow_q;
            end
            if (matrix_valid) begin
                for (int k = 0; k < 9; k++) begin
                    shadow_q[k] <= comp_matrix[32*k +: 32];
                end
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Stage 1: nine coefficient x channel products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                p1_q[k] <= '0;
            end
        end else if (en) begin
            v1_q   <= in_valid;
            sof1_q <= in_sof;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    p1_q[3*r+c] <= PROD_W'(sel_m[3*r+c])
                                 * PROD_W'($signed({1'b0, in_rgb[PIX_W*c +: PIX_W]}));
                end
            end
        end
    end

    // Stage 2: per-row sum of products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sof2_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                s2_q[r] <= '0;
            end
        end else if (en) begin
            v2_q   <= v1_q;
            sof2_q <= sof1_q;
            for (int r = 0; r < 3; r++) begin
                s2_q[r] <= SUM_W'(p1_q[3*r]) + SUM_W'(p1_q[3*r+1]) + SUM_W'(p1_q[3*r+2]);
            end
        end
    end

    // Round half up to integer, then clamp into the unsigned channel range
    always_comb begin
        res_rgb = '0;
        for (int r = 0; r < 3; r++) begin
            rnd[r] = (s2_q[r] + HALF) >>> FRAC_BITS;
            if (rnd[r][SUM_W-1]) begin
                res_rgb[PIX_W*r +: PIX_W] = '0;
            end else if (rnd[r] > MAXV) begin
                res_rgb[PIX_W*r +: PIX_W] = '1;
            end else begin
                res_rgb[PIX_W*r +: PIX_W] = rnd[r][PIX_W-1:0];
            end
        end
    end

    // Stage 3: output register, holds while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            sof3_q <= 1'b0;
            rgb3_q <= '0;
        end else if (en) begin
            v3_q   <= v2_q;
            sof3_q <= sof2_q;
            rgb3_q <= res_rgb;
        end
    end
endmodule

// File: tb/tb_chromatic_matrix_apply.sv
// tb/tb_chromatic_matrix_apply.sv - directed self-checking bench for chromatic_matrix_apply
module tb_chromatic_matrix_apply;
    logic         clk = 1'b0;
    logic         rst;
    logic [287:0] comp_matrix;
    logic         matrix_valid;
    logic [23:0]  in_rgb;
    logic         in_sof;
    logic         in_valid;
    logic         in_ready;
    logic [23:0]  out_rgb;
    logic         out_sof;
    logic         out_valid;
    logic         out_ready;
    logic         matrix_pending;

    int checks   = 0;
    int failures = 0;

    chromatic_matrix_apply dut (
        .clk            (clk),
        .rst            (rst),
        .comp_matrix    (comp_matrix),
        .matrix_valid   (matrix_valid),
        .in_rgb         (in_rgb),
        .in_sof         (in_sof),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_rgb        (out_rgb),
        .out_sof        (out_sof),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .matrix_pending (matrix_pending)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [287:0] diag(input logic [31:0] d);
        logic [287:0] m;
        m = '0;
        m[31:0]    = d;
        m[159:128] = d;
        m[287:256] = d;
        return m;
    endfunction

    function automatic logic [23:0] ramp(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b, b};
    endfunction

    task automatic load_matrix(input logic [287:0] m);
        comp_matrix  = m;
        matrix_valid = 1'b1;
        tick;
        matrix_valid = 1'b0;
    endtask

    // One isolated pixel: exact 3-cycle latency, value and sof, then drain
    task automatic send_check(input string tag, input logic [23:0] rgb, input logic sof,
                              input logic mv, input logic [23:0] exp_rgb);
        in_rgb       = rgb;
        in_sof       = sof;
        in_valid     = 1'b1;
        matrix_valid = mv;
        tick;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        matrix_valid = 1'b0;
        tick;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_rgb"}, {8'd0, out_rgb}, {8'd0, exp_rgb});
        check({tag, "_sof"}, {31'd0, out_sof}, {31'd0, sof});
        tick;
    endtask

    initial begin
        int sent;
        int rcvd;
        int cyc;
        int vcount;
        logic acc_in;
        logic acc_out;
        logic [23:0] hold;

        rst          = 1'b1;
        comp_matrix  = '0;
        matrix_valid = 1'b0;
        in_rgb       = '0;
        in_sof       = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        hold         = '0;
        repeat (2) tick;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_rgb", {8'd0, out_rgb}, 32'd0);
        check("rst_out_sof", {31'd0, out_sof}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pending", {31'd0, matrix_pending}, 32'd0);
        rst = 1'b0;
        tick;

        // T1 identity after reset
        send_check("t1_identity", 24'h204080, 1'b1, 1'b0, 24'h204080);

        // T2 clamp and rounding
        load_matrix(diag(32'h0002_0000));
        check("t2_pending_set", {31'd0, matrix_pending}, 32'd1);
        send_check("t2_gain2", 24'h7F1080, 1'b1, 1'b0, 24'hFE20FF);
        check("t2_pending_clr", {31'd0, matrix_pending}, 32'd0);
        load_matrix(diag(32'h0000_8000));
        send_check("t2_half", 24'hFF0301, 1'b1, 1'b0, 24'h800201);
        load_matrix({32'h0001_0000, 96'd0, 32'h0001_0000, 96'd0, 32'hFFFF_0000});
        send_check("t2_neg", 24'h302010, 1'b1, 1'b0, 24'h302000);

        // T3 frame-synchronous commit
        load_matrix(diag(32'h0001_0000));
        send_check("t3_ident_sof", 24'h010203, 1'b1, 1'b0, 24'h010203);
        send_check("t3_ident_px", 24'h050505, 1'b0, 1'b0, 24'h050505);
        load_matrix(diag(32'h0002_0000));
        check("t3_pending_mid", {31'd0, matrix_pending}, 32'd1);
        send_check("t3_keep_ident", 24'h0A0B0C, 1'b0, 1'b0, 24'h0A0B0C);
        check("t3_still_pending", {31'd0, matrix_pending}, 32'd1);
        send_check("t3_new_sof", 24'h010203, 1'b1, 1'b0, 24'h020406);
        check("t3_pending_done", {31'd0, matrix_pending}, 32'd0);
        send_check("t3_new_px", 24'h111111, 1'b0, 1'b0, 24'h222222);

        // T4 strobe coincident with SOF, nothing pending
        comp_matrix = diag(32'h0001_0000);
        send_check("t4_sof_old", 24'h101010, 1'b1, 1'b1, 24'h202020);
        check("t4_pending", {31'd0, matrix_pending}, 32'd1);
        send_check("t4_px_old", 24'h030303, 1'b0, 1'b0, 24'h060606);
        send_check("t4_next_sof", 24'h030303, 1'b1, 1'b0, 24'h030303);
        check("t4_pending_clr", {31'd0, matrix_pending}, 32'd0);

        // T5 back-pressure on a 20-pixel ramp
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 20 && cyc < 100) begin
            out_ready = !(cyc >= 8 && cyc < 13);
            in_valid  = (sent < 20);
            in_rgb    = ramp(sent);
            in_sof    = (sent == 0);
            #1;
            if (cyc == 8) begin
                check("t5_stall_ready", {31'd0, in_ready}, 32'd0);
                hold = out_rgb;
            end
            if (cyc == 12) begin
                check("t5_hold", {8'd0, out_rgb}, {8'd0, hold});
            end
            acc_in  = in_valid & in_ready;
            acc_out = out_valid & out_ready;
            if (acc_out) begin
                check("t5_order", {8'd0, out_rgb}, {8'd0, ramp(rcvd)});
                rcvd++;
            end
            tick;
            if (acc_in) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        check("t5_count", rcvd, 32'd20);
        repeat (3) tick;

        // T6 reset with pixels in flight
        in_valid = 1'b1;
        in_rgb   = 24'hAAAAAA;
        tick;
        in_rgb   = 24'hBBBBBB;
        tick;
        in_rgb   = 24'hCCCCCC;
        tick;
        in_valid = 1'b0;
        check("t6_inflight", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        tick;
        tick;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) vcount++;
            tick;
        end
        check("t6_no_ghost", vcount, 32'd0);
        send_check("t6_after", 24'h0A0B0C, 1'b1, 1'b0, 24'h0A0B0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
